// File: rtl/adc_capture_sequencer_if.sv
// adc_capture_sequencer_if
// Groups the storage-FIFO read port and the UART transmit write port that the
// capture sequencer drives.
//   FifoNotEmpty   : FIFO has data
//   FifoData       : FIFO read data, valid the cycle after FifoReadEnable
//   FifoReadEnable : one-cycle FIFO pop
//   TxData         : byte to the UART
//   TxWrite        : one-cycle UART write strobe
//   TxBusy         : UART is shifting
// Modports: master = sequencer side, slave = FIFO/UART side.
interface adc_capture_sequencer_if;
  logic       FifoNotEmpty;
  logic [7:0] FifoData;
  logic       FifoReadEnable;
  logic [7:0] TxData;
  logic       TxWrite;
  logic       TxBusy;

  modport master (
    input  FifoNotEmpty, FifoData, TxBusy,
    output FifoReadEnable, TxData, TxWrite
  );

  modport slave (
    output FifoNotEmpty, FifoData, TxBusy,
    input  FifoReadEnable, TxData, TxWrite
  );
endinterface

// File: rtl/adc_capture_sequencer.sv
// adc_capture_sequencer
// Sequences one ADC capture: arm, fire the FIFO trigger, drain SAMPLE_COUNT
// bytes from the storage FIFO and frame them as header / data / checksum on the
// UART transmit port.
// Ports:
//   Clock        : system clock, rising edge
//   Reset        : synchronous, active-high
//   Arm          : start request, honoured in idle only
//   ForceTrigger : software trigger, honoured when armed only
//   ExtTrigger   : external trigger level, rising edge triggers when armed
//   TriggerOut   : one-cycle pulse to the storage FIFO trigger input
//   Busy         : high in every state except idle
//   Done         : one-cycle pulse when the footer is written
//   TimeoutFlag  : sticky FIFO-starvation flag, cleared by the next accepted Arm
//   bus          : FIFO read / UART write port (master side)
// All outputs are registered.
module adc_capture_sequencer #(
  parameter int unsigned SAMPLE_COUNT   = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter logic [7:0]  HEADER_BYTE    = 8'hA5
) (
  input  logic                           Clock,
  input  logic                           Reset,
  input  logic                           Arm,
  input  logic                           ForceTrigger,
  input  logic                           ExtTrigger,
  output logic                           TriggerOut,
  output logic                           Busy,
  output logic                           Done,
  output logic                           TimeoutFlag,
  adc_capture_sequencer_if.master        bus
);

  localparam int unsigned ToW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [3:0] {
    StIdle, StArmed, StFire, StHeader, StPop, StLatch, StSend, StFooter, StDone
  } stateType;

  stateType       stateQ, stateD;
  logic           extPrevQ;
  logic [15:0]    byteCntQ, byteCntD;
  logic [7:0]     checksumQ, checksumD;
  logic [ToW-1:0] toCntQ, toCntD;
  logic           timeoutQ, timeoutD;
  logic [7:0]     txDataQ, txDataD;
  logic           txWriteQ, txWriteD;
  logic           fifoReadQ, fifoReadD;
  logic           triggerQ, busyQ, doneQ;

  logic           txReady;
  logic           extEdge;
  logic [16:0]    byteCntInc;

  always_comb begin
    stateD     = stateQ;
    byteCntD   = byteCntQ;
    checksumD  = checksumQ;
    toCntD     = toCntQ;
    timeoutD   = timeoutQ;
    txDataD    = txDataQ;
    txWriteD   = 1'b0;
    fifoReadD  = 1'b0;
    // TxBusy may lag our TxWrite by a cycle, so the write cycle itself counts as busy.
    txReady    = !bus.TxBusy && !txWriteQ;
    extEdge    = ExtTrigger && !extPrevQ;
    byteCntInc = {1'b0, byteCntQ} + 17'd1;

    unique case (stateQ)
      StIdle: begin
        if (Arm) begin
          stateD    = StArmed;
          timeoutD  = 1'b0;
          byteCntD  = '0;
          checksumD = '0;
        end
      end
      StArmed: begin
        if (ForceTrigger || extEdge) stateD = StFire;
      end
      StFire: stateD = StHeader;
      StHeader: begin
        if (txReady) begin
          txDataD  = HEADER_BYTE;
          txWriteD = 1'b1;
          toCntD   = '0;
          stateD   = StPop;
        end
      end
      StPop: begin
        if (bus.FifoNotEmpty && txReady) begin
          fifoReadD = 1'b1;
          stateD    = StLatch;
        end else if (!bus.FifoNotEmpty) begin
          if (toCntQ == ToW'(TIMEOUT_CYCLES - 1)) begin
            timeoutD = 1'b1;
            stateD   = StIdle;
          end else begin
            toCntD = toCntQ + ToW'(1);
          end
        end
      end
      // The registered pop lands at the end of this cycle; data is valid in StSend.
      StLatch: stateD = StSend;
      StSend: begin
        txDataD   = bus.FifoData;
        txWriteD  = 1'b1;
        checksumD = checksumQ + bus.FifoData;
        byteCntD  = byteCntInc[15:0];
        toCntD    = '0;
        stateD    = (byteCntInc < 17'(SAMPLE_COUNT)) ? StPop : StFooter;
      end
      StFooter: begin
        if (txReady) begin
          txDataD  = checksumQ;
          txWriteD = 1'b1;
          stateD   = StDone;
        end
      end
      StDone:  stateD = StIdle;
      default: stateD = StIdle;
    endcase
  end

  always_ff @(posedge Clock) begin
    // Edge detector runs every cycle so a level already high at arm time is not an edge.
    extPrevQ <= ExtTrigger;
    if (Reset) begin
      stateQ    <= StIdle;
      byteCntQ  <= '0;
      checksumQ <= '0;
      toCntQ    <= '0;
      timeoutQ  <= 1'b0;
      txDataQ   <= '0;
      txWriteQ  <= 1'b0;
      fifoReadQ <= 1'b0;
      triggerQ  <= 1'b0;
      busyQ     <= 1'b0;
      doneQ     <= 1'b0;
    end else begin
      stateQ    <= stateD;
      byteCntQ  <= byteCntD;
      checksumQ <= checksumD;
      toCntQ    <= toCntD;
      timeoutQ  <= timeoutD;
      txDataQ   <= txDataD;
      txWriteQ  <= txWriteD;
      fifoReadQ <= fifoReadD;
      triggerQ  <= (stateD == StFire);
      busyQ     <= (stateD != StIdle);
      doneQ     <= (stateD == StDone);
    end
  end

  assign TriggerOut         = triggerQ;
  assign Busy               = busyQ;
  assign Done               = doneQ;
  assign TimeoutFlag        = timeoutQ;
  assign bus.TxData         = txDataQ;
  assign bus.TxWrite        = txWriteQ;
  assign bus.FifoReadEnable = fifoReadQ;

endmodule
